game_flow_sequencer: RTL and testbench
======================================

// Module: game_flow_sequencer
// PURPOSE
// - Top-level stage sequencer for the multi-game OLED design. Owns start screen, timed transition slides, N game stages, retry and finish.
// - Muxes one 16-bit pixel stream onto the OLED and one seg/an pair onto the 7-seg display.
// - Issues one-hot stage enables and restart pulses to the game modules.
// - Generalises the hard-wired 4-stage flow: stage count, slide hold time and slide skipping are parameters.
// - Adds a per-stage fail/retry path.
// PARAMETERS
// NUM_STAGES   4            number of game stages (1..8)
// HOLD_CYCLES  300_000_000  CLOCK cycles each transition slide is shown (3 s at 100 MHz)
// CNT_W        32           hold counter width; must hold HOLD_CYCLES-1
// ALLOW_SKIP   1            1: a start press during a slide ends the slide early
// PORTS
// CLOCK        in   1               100 MHz system clock
// reset        in   1               asynchronous, active-high
// start        in   1               raw button level (btnC); synchronised internally
// stage_done   in   NUM_STAGES      level; stage i has been completed
// stage_fail   in   NUM_STAGES      level; stage i has been failed (lives exhausted)
// start_pix    in   16              start-screen pixel
// slide_pix    in   16*NUM_STAGES   transition slide pixel shown before stage i
// game_pix     in   16*NUM_STAGES   game pixel for stage i
// retry_pix    in   16              try-again screen pixel
// end_pix      in   16              finish screen pixel
// stage_seg    in   7*NUM_STAGES    7-seg segments from stage i
// stage_an     in   4*NUM_STAGES    7-seg anodes from stage i
// oled_data    out  16              registered pixel to Oled_Display
// seg          out  7               registered segments; active-low
// an           out  4               registered anodes; active-low
// stage_en     out  NUM_STAGES      one-hot; only the current stage while in PLAY or RETRY
// stage_restart out NUM_STAGES      one-cycle pulse when a stage is (re)entered in PLAY
// stage_idx    out  3               current stage index
// all_done     out  1               high in FINISH
// BEHAVIOUR
// - Reset state: IDLE. Reset values: idx=0, counter=0, oled_data=0, seg=7'h7F, an=4'hF, stage_en=0, stage_restart=0, all_done=0.
// - start path: 2-flop synchroniser, then rising-edge detector. start_pe is one cycle wide.
// - IDLE
//   - Display: start_pix.
//   - start_pe -> SLIDE, idx=0, counter cleared.
// - SLIDE
//   - Display: slide_pix[idx].
//   - counter increments each cycle. At counter==HOLD_CYCLES-1 -> PLAY.
//   - If ALLOW_SKIP=1, start_pe also -> PLAY.
//   - Entering PLAY pulses stage_restart[idx] for 1 cycle.
// - PLAY
//   - Display: game_pix[idx]; seg/an = stage_seg/an[idx].
//   - stage_done[idx]:
//     - idx==NUM_STAGES-1 -> FINISH.
//     - otherwise -> SLIDE with idx+1 and counter cleared.
//   - stage_fail[idx] -> RETRY.
//   - If done and fail are both high, done wins.
//   - Inputs from stages other than idx are ignored.
// - RETRY
//   - Display: retry_pix; seg/an blank.
//   - stage_en stays asserted so the stage can hold its state.
//   - start_pe -> PLAY on the same idx, with a stage_restart[idx] pulse.
// - FINISH
//   - Display: end_pix; all_done=1.
//   - Terminal state; left only by reset.
// - Outside PLAY: seg=7'h7F, an=4'hF.
// - Latency: oled_data/seg/an are registered from the current state and index. The output follows a state change by 1 cycle; no combinational path from inputs to outputs.
// - Counter saturates at HOLD_CYCLES-1 and is cleared on every SLIDE entry.
// - A start_pe that causes a transition is consumed. It does not also act in the next state, e.g. the IDLE press does not skip slide 0.
// - Reset asserted mid-slide or mid-game: immediate return to IDLE and all reset values; no partial pulses.
// STRUCTURE
// - game_flow_pkg.vh holds:
//   - state encodings: ST_IDLE, ST_SLIDE, ST_PLAY, ST_RETRY, ST_FINISH (3 bits);
//   - SEG_BLANK=7'h7F and AN_BLANK=4'hF.
// - Sub-module hold_timer (CNT_W, HOLD_CYCLES): inputs clear and enable; output expired. Contains the saturating counter.
// - Top: FSM, synchroniser/edge detect, indexed part-selects for the pixel and seg mux.
// TESTING (NUM_STAGES=3, HOLD_CYCLES=10, ALLOW_SKIP=0 unless stated)
// - Reset, then start pulse -> SLIDE idx0 1 cycle after the edge is detected; oled_data=slide_pix[0] for exactly 10 cycles; stage_restart[0] pulses once; stage_en=3'b001.
// - stage_done[0]=1 in PLAY -> SLIDE idx1. stage_done[2] asserted while idx=1 -> ignored, stays in PLAY.
// - stage_done[1] and stage_fail[1] both high in the same cycle -> SLIDE idx2, not RETRY.
// - stage_fail[2] -> oled_data=retry_pix, seg=7'h7F. Then start pulse -> PLAY idx2 with a stage_restart[2] pulse; seg=stage_seg[2].
// - stage_done[2] -> FINISH; all_done=1; oled_data=end_pix; further start pulses produce no change.
// - ALLOW_SKIP=1: start pulse 3 cycles into a slide -> PLAY on the next cycle. Reset asserted at slide cycle 5 -> IDLE, oled_data=start_pix, counter=0.

Source files
------------

// File: rtl/game_flow_sequencer_pkg.sv
// Shared encodings for the game flow sequencer: FSM states and blank 7-seg codes.
package game_flow_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SLIDE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_RETRY  = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_BLANK  = 4'hF;

endpackage

// File: rtl/game_flow_sequencer_hold_timer.sv
// Saturating hold counter for transition slides; expired is high once the
// count reaches HOLD_CYCLES-1 and stays there until cleared.
module hold_timer #(
  parameter int CNT_W       = 32,
  parameter int HOLD_CYCLES = 300_000_000
) (
  input  logic CLOCK,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] count_r;

  // Count while enabled, saturating at LAST; clear has priority.
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (enable && (count_r != LAST)) begin
      count_r <= count_r + CNT_W'(1);
    end
  end

  assign expired = (count_r == LAST);

endmodule

// File: rtl/game_flow_sequencer.sv
// Stage sequencer: start screen, timed slides, N game stages with retry, finish.
// Muxes OLED pixels and 7-seg signals from the active stage onto registered outputs.
module game_flow_sequencer
  import game_flow_sequencer_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 300_000_000,
  parameter int CNT_W       = 32,
  parameter int ALLOW_SKIP  = 1
) (
  input  logic                      CLOCK,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUM_STAGES-1:0]     stage_done,
  input  logic [NUM_STAGES-1:0]     stage_fail,
  input  logic [15:0]               start_pix,
  input  logic [16*NUM_STAGES-1:0]  slide_pix,
  input  logic [16*NUM_STAGES-1:0]  game_pix,
  input  logic [15:0]               retry_pix,
  input  logic [15:0]               end_pix,
  input  logic [7*NUM_STAGES-1:0]   stage_seg,
  input  logic [4*NUM_STAGES-1:0]   stage_an,
  output logic [15:0]               oled_data,
  output logic [6:0]                seg,
  output logic [3:0]                an,
  output logic [NUM_STAGES-1:0]     stage_en,
  output logic [NUM_STAGES-1:0]     stage_restart,
  output logic [2:0]                stage_idx,
  output logic                      all_done
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_STAGES - 1);

  logic   sync1_r, sync2_r, start_prev_r, start_pe_s;
  state_t state_r, next_state_s;
  logic [2:0] idx_r, next_idx_s;
  logic   expired_s, done_sel_s, fail_sel_s;
  logic [5:0] seg_amt_s;
  logic [15:0] pix_s;
  logic [6:0]  seg_s;
  logic [3:0]  an_s;
  logic [NUM_STAGES-1:0] onehot_s, en_s, restart_s;
  logic   all_done_s;

  // Two-flop synchroniser on the raw button plus a delayed copy for edge detect.
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      sync1_r      <= 1'b0;
      sync2_r      <= 1'b0;
      start_prev_r <= 1'b0;
    end else begin
      sync1_r      <= start;
      sync2_r      <= sync1_r;
      start_prev_r <= sync2_r;
    end
  end

  assign start_pe_s = sync2_r & ~start_prev_r;
  assign done_sel_s = 1'(stage_done >> idx_r);
  assign fail_sel_s = 1'(stage_fail >> idx_r);

  // The timer is held clear outside SLIDE, so every slide entry starts at zero.
  hold_timer #(.CNT_W(CNT_W), .HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
    .CLOCK   (CLOCK),
    .reset   (reset),
    .clear   (state_r != ST_SLIDE),
    .enable  (state_r == ST_SLIDE),
    .expired (expired_s)
  );

  // State and stage index register.
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      idx_r   <= 3'd0;
    end else begin
      state_r <= next_state_s;
      idx_r   <= next_idx_s;
    end
  end

  // Next-state logic; done beats fail, other stages' inputs are masked by idx.
  always_comb begin
    next_state_s = state_r;
    next_idx_s   = idx_r;
    case (state_r)
      ST_IDLE: begin
        if (start_pe_s) begin
          next_state_s = ST_SLIDE;
          next_idx_s   = 3'd0;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SLIDE: begin
        if (expired_s || ((ALLOW_SKIP != 0) && start_pe_s)) begin
          next_state_s = ST_PLAY;
        end else begin
          next_state_s = ST_SLIDE;
        end
      end
      ST_PLAY: begin
        if (done_sel_s) begin
          if (idx_r == LAST_IDX) begin
            next_state_s = ST_FINISH;
          end else begin
            next_state_s = ST_SLIDE;
            next_idx_s   = idx_r + 3'd1;
          end
        end else if (fail_sel_s) begin
          next_state_s = ST_RETRY;
        end else begin
          next_state_s = ST_PLAY;
        end
      end
      ST_RETRY: begin
        if (start_pe_s) begin
          next_state_s = ST_PLAY;
        end else begin
          next_state_s = ST_RETRY;
        end
      end
      ST_FINISH: next_state_s = ST_FINISH;
      default: begin
        next_state_s = ST_IDLE;
        next_idx_s   = 3'd0;
      end
    endcase
  end

  assign seg_amt_s = {3'b000, idx_r} * 6'd7;
  assign onehot_s  = NUM_STAGES'(1'b1) << next_idx_s;

  // Output decode: display mux from current state, stage controls from next state.
  always_comb begin
    pix_s = 16'h0000;
    seg_s = SEG_BLANK;
    an_s  = AN_BLANK;
    case (state_r)
      ST_IDLE:   pix_s = start_pix;
      ST_SLIDE:  pix_s = 16'(slide_pix >> {idx_r, 4'b0000});
      ST_PLAY: begin
        pix_s = 16'(game_pix >> {idx_r, 4'b0000});
        seg_s = 7'(stage_seg >> seg_amt_s);
        an_s  = 4'(stage_an >> {idx_r, 2'b00});
      end
      ST_RETRY:  pix_s = retry_pix;
      ST_FINISH: pix_s = end_pix;
      default:   pix_s = 16'h0000;
    endcase
    if ((next_state_s == ST_PLAY) || (next_state_s == ST_RETRY)) begin
      en_s = onehot_s;
    end else begin
      en_s = {NUM_STAGES{1'b0}};
    end
    if ((next_state_s == ST_PLAY) && (state_r != ST_PLAY)) begin
      restart_s = onehot_s;
    end else begin
      restart_s = {NUM_STAGES{1'b0}};
    end
    all_done_s = (next_state_s == ST_FINISH);
  end

  // Registered outputs.
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      oled_data     <= 16'h0000;
      seg           <= SEG_BLANK;
      an            <= AN_BLANK;
      stage_en      <= {NUM_STAGES{1'b0}};
      stage_restart <= {NUM_STAGES{1'b0}};
      all_done      <= 1'b0;
    end else begin
      oled_data     <= pix_s;
      seg           <= seg_s;
      an            <= an_s;
      stage_en      <= en_s;
      stage_restart <= restart_s;
      all_done      <= all_done_s;
    end
  end

  assign stage_idx = idx_r;

endmodule

// File: tb/tb_game_flow_sequencer.sv
// Bench for game_flow_sequencer: two instances (skip disabled / enabled) checked
// every cycle against a behavioural flow model, plus directed scenario checks.
module tb_game_flow_sequencer;

  localparam int N    = 3;
  localparam int HOLD = 10;
  localparam int M_IDLE = 0, M_SLIDE = 1, M_PLAY = 2, M_RETRY = 3, M_FINISH = 4;
  localparam logic [36:0] RST_VEC = {16'h0000, 7'h7F, 4'hF, 3'b000, 3'b000, 3'b000, 1'b0};

  logic CLOCK = 1'b0;
  logic reset, start;
  logic [N-1:0] stage_done, stage_fail;
  logic [15:0] start_pix, retry_pix, end_pix;
  logic [16*N-1:0] slide_pix, game_pix;
  logic [7*N-1:0] stage_seg;
  logic [4*N-1:0] stage_an;

  logic [15:0]  oled_data [2];
  logic [6:0]   seg [2];
  logic [3:0]   an [2];
  logic [N-1:0] stage_en [2];
  logic [N-1:0] stage_restart [2];
  logic [2:0]   stage_idx [2];
  logic         all_done [2];
  logic [36:0]  obs [2];

  int mode [2], idx [2], left [2];
  logic [36:0] expv [2];
  logic [2:0] hist;
  int checks = 0;
  int fails = 0;

  always #5 CLOCK = ~CLOCK;

  game_flow_sequencer #(.NUM_STAGES(N), .HOLD_CYCLES(HOLD), .CNT_W(8), .ALLOW_SKIP(0)) dut0 (
    .CLOCK(CLOCK), .reset(reset), .start(start), .stage_done(stage_done), .stage_fail(stage_fail),
    .start_pix(start_pix), .slide_pix(slide_pix), .game_pix(game_pix), .retry_pix(retry_pix),
    .end_pix(end_pix), .stage_seg(stage_seg), .stage_an(stage_an), .oled_data(oled_data[0]),
    .seg(seg[0]), .an(an[0]), .stage_en(stage_en[0]), .stage_restart(stage_restart[0]),
    .stage_idx(stage_idx[0]), .all_done(all_done[0]));

  game_flow_sequencer #(.NUM_STAGES(N), .HOLD_CYCLES(HOLD), .CNT_W(8), .ALLOW_SKIP(1)) dut1 (
    .CLOCK(CLOCK), .reset(reset), .start(start), .stage_done(stage_done), .stage_fail(stage_fail),
    .start_pix(start_pix), .slide_pix(slide_pix), .game_pix(game_pix), .retry_pix(retry_pix),
    .end_pix(end_pix), .stage_seg(stage_seg), .stage_an(stage_an), .oled_data(oled_data[1]),
    .seg(seg[1]), .an(an[1]), .stage_en(stage_en[1]), .stage_restart(stage_restart[1]),
    .stage_idx(stage_idx[1]), .all_done(all_done[1]));

  for (genvar g = 0; g < 2; g++) begin : g_obs
    assign obs[g] = {oled_data[g], seg[g], an[g], stage_en[g], stage_restart[g], stage_idx[g], all_done[g]};
  end

  // Flow model: what each instance should show after the coming clock edge.
  task automatic model_step();
    logic pe;
    logic [15:0] p;
    logic [6:0] sg;
    logic [3:0] a;
    logic [N-1:0] oh, en_e, rs_e;
    int om;
    pe = hist[1] & ~hist[2];
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        mode[m] = M_IDLE; idx[m] = 0; left[m] = 0; expv[m] = RST_VEC;
      end else begin
        sg = 7'h7F; a = 4'hF;
        case (mode[m])
          M_IDLE:  p = start_pix;
          M_SLIDE: p = slide_pix[idx[m]*16 +: 16];
          M_PLAY: begin
            p = game_pix[idx[m]*16 +: 16]; sg = stage_seg[idx[m]*7 +: 7]; a = stage_an[idx[m]*4 +: 4];
          end
          M_RETRY: p = retry_pix;
          default: p = end_pix;
        endcase
        om = mode[m];
        case (mode[m])
          M_IDLE: if (pe) begin mode[m] = M_SLIDE; idx[m] = 0; left[m] = HOLD; end
          M_SLIDE: if (left[m] == 1 || (m == 1 && pe)) mode[m] = M_PLAY; else left[m]--;
          M_PLAY: begin
            if (stage_done[idx[m]]) begin
              if (idx[m] == N-1) mode[m] = M_FINISH;
              else begin idx[m]++; mode[m] = M_SLIDE; left[m] = HOLD; end
            end else if (stage_fail[idx[m]]) mode[m] = M_RETRY;
          end
          M_RETRY: if (pe) mode[m] = M_PLAY;
          default: ;
        endcase
        oh = '0; oh[idx[m]] = 1'b1;
        en_e = (mode[m] == M_PLAY || mode[m] == M_RETRY) ? oh : '0;
        rs_e = (mode[m] == M_PLAY && om != M_PLAY) ? oh : '0;
        expv[m] = {p, sg, a, en_e, rs_e, 3'(idx[m]), (mode[m] == M_FINISH)};
      end
    end
    hist = reset ? 3'b000 : {hist[1:0], start};
  endtask

  task automatic tick();
    model_step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stage_done = '0; stage_fail = '0; hist = 3'b000;
    tick(); tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs[m] !== RST_VEC) begin fails++; $display("FAIL reset_values dut%0d: got %h expected %h", m, obs[m], RST_VEC); end
    end
    reset = 1'b0;
    tick();
    checks++;
    if (oled_data[0] !== start_pix) begin fails++; $display("FAIL idle_pix: got %h expected %h", oled_data[0], start_pix); end
  endtask

  task automatic test_start_slide();
    int hits = 0, pulses = 0;
    for (int i = 0; i < 20; i++) begin
      start = (i < 2);
      tick();
      if (oled_data[0] === slide_pix[15:0]) hits++;
      if (stage_restart[0] === 3'b001) pulses++;
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== expv[m]) begin fails++; $display("FAIL start_slide dut%0d cyc%0d: got %h expected %h", m, i, obs[m], expv[m]); end
      end
    end
    checks++;
    if (hits != 10) begin fails++; $display("FAIL slide0_len: got %0d expected 10", hits); end
    checks++;
    if (pulses != 1) begin fails++; $display("FAIL restart0_pulses: got %0d expected 1", pulses); end
    checks++;
    if (stage_en[0] !== 3'b001) begin fails++; $display("FAIL stage_en0: got %b expected 001", stage_en[0]); end
  endtask

  task automatic test_advance();
    for (int i = 0; i < 22; i++) begin
      stage_done = (i == 0) ? 3'b001 : (i >= 16 ? 3'b100 : 3'b000);
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== expv[m]) begin fails++; $display("FAIL advance dut%0d cyc%0d: got %h expected %h", m, i, obs[m], expv[m]); end
      end
    end
    stage_done = '0;
    checks++;
    if (stage_idx[0] !== 3'd1 || stage_en[0] !== 3'b010) begin
      fails++; $display("FAIL ignore_other_done: got idx %0d en %b expected idx 1 en 010", stage_idx[0], stage_en[0]);
    end
    checks++;
    if (oled_data[0] !== game_pix[31:16]) begin fails++; $display("FAIL game1_pix: got %h expected %h", oled_data[0], game_pix[31:16]); end
  endtask

  task automatic test_done_fail_both();
    bit saw_retry = 1'b0;
    for (int i = 0; i < 16; i++) begin
      stage_done = (i == 0) ? 3'b010 : 3'b000;
      stage_fail = (i == 0) ? 3'b010 : 3'b000;
      tick();
      if (oled_data[0] === retry_pix) saw_retry = 1'b1;
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== expv[m]) begin fails++; $display("FAIL done_wins dut%0d cyc%0d: got %h expected %h", m, i, obs[m], expv[m]); end
      end
    end
    checks++;
    if (stage_idx[0] !== 3'd2 || saw_retry || stage_en[0] !== 3'b100) begin
      fails++; $display("FAIL done_beats_fail: got idx %0d retry %0d en %b expected idx 2 retry 0 en 100", stage_idx[0], saw_retry, stage_en[0]);
    end
  endtask

  task automatic test_retry();
    int pulses = 0;
    for (int i = 0; i < 4; i++) begin
      stage_fail = (i == 0) ? 3'b100 : 3'b000;
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== expv[m]) begin fails++; $display("FAIL retry_enter dut%0d cyc%0d: got %h expected %h", m, i, obs[m], expv[m]); end
      end
    end
    checks++;
    if (oled_data[0] !== retry_pix || seg[0] !== 7'h7F || an[0] !== 4'hF || stage_en[0] !== 3'b100) begin
      fails++; $display("FAIL retry_screen: got pix %h seg %h an %h en %b expected %h 7f f 100", oled_data[0], seg[0], an[0], stage_en[0], retry_pix);
    end
    for (int i = 0; i < 6; i++) begin
      start = (i < 2);
      tick();
      if (stage_restart[0] === 3'b100) pulses++;
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== expv[m]) begin fails++; $display("FAIL retry_resume dut%0d cyc%0d: got %h expected %h", m, i, obs[m], expv[m]); end
      end
    end
    checks++;
    if (pulses != 1 || seg[0] !== stage_seg[20:14] || oled_data[0] !== game_pix[47:32]) begin
      fails++; $display("FAIL retry_restart: got pulses %0d seg %h pix %h expected 1 %h %h", pulses, seg[0], oled_data[0], stage_seg[20:14], game_pix[47:32]);
    end
  endtask

  task automatic test_finish();
    for (int i = 0; i < 20; i++) begin
      stage_done = (i == 0) ? 3'b100 : 3'b000;
      start = (i >= 4) && ((i % 4) < 2);
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== expv[m]) begin fails++; $display("FAIL finish dut%0d cyc%0d: got %h expected %h", m, i, obs[m], expv[m]); end
      end
    end
    start = 1'b0;
    checks++;
    if (all_done[0] !== 1'b1 || oled_data[0] !== end_pix || stage_en[0] !== 3'b000) begin
      fails++; $display("FAIL finish_state: got done %b pix %h en %b expected 1 %h 000", all_done[0], oled_data[0], stage_en[0], end_pix);
    end
  endtask

  task automatic test_skip_and_reset();
    int hits0 = 0, hits1 = 0;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      start = (i < 2) || (i == 3) || (i == 4);
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== expv[m]) begin fails++; $display("FAIL skip dut%0d cyc%0d: got %h expected %h", m, i, obs[m], expv[m]); end
      end
      if (i == 5) begin
        checks++;
        if (stage_restart[1] !== 3'b001 || stage_restart[0] !== 3'b000) begin
          fails++; $display("FAIL skip_to_play: got r1 %b r0 %b expected 001 000", stage_restart[1], stage_restart[0]);
        end
      end
    end
    reset = 1'b1;
    model_step();
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs[m] !== RST_VEC) begin fails++; $display("FAIL async_reset dut%0d: got %h expected %h", m, obs[m], RST_VEC); end
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (oled_data[0] !== start_pix) begin fails++; $display("FAIL reset_idle_pix: got %h expected %h", oled_data[0], start_pix); end
    for (int i = 0; i < 18; i++) begin
      start = (i < 2);
      tick();
      if (oled_data[0] === slide_pix[15:0]) hits0++;
      if (oled_data[1] === slide_pix[15:0]) hits1++;
    end
    checks++;
    if (hits0 != 10 || hits1 != 10) begin fails++; $display("FAIL counter_cleared: got %0d/%0d expected 10/10", hits0, hits1); end
  endtask

  task automatic test_random();
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      start = ($urandom_range(0, 2) == 0);
      stage_done = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      stage_fail = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      start_pix = 16'($urandom); retry_pix = 16'($urandom); end_pix = 16'($urandom);
      slide_pix = {16'($urandom), 16'($urandom), 16'($urandom)};
      game_pix  = {16'($urandom), 16'($urandom), 16'($urandom)};
      stage_seg = 21'($urandom); stage_an = 12'($urandom);
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== expv[m]) begin fails++; $display("FAIL random dut%0d cyc%0d: got %h expected %h", m, i, obs[m], expv[m]); end
      end
    end
  endtask

  initial begin
    start_pix = 16'h1111; retry_pix = 16'h7777; end_pix = 16'hEEEE;
    slide_pix = {16'h5302, 16'h5201, 16'h5100};
    game_pix  = {16'h6302, 16'h6201, 16'h6100};
    stage_seg = {7'h24, 7'h12, 7'h79};
    stage_an  = {4'hB, 4'hD, 4'hE};
    test_reset();
    test_start_slide();
    test_advance();
    test_done_fail_both();
    test_retry();
    test_finish();
    test_skip_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
